// File: rtl/Falco_pkg.sv
// Core-wide width definitions shared across the Falco pipeline.
package Falco_pkg;
    localparam int FALCO_XLEN = 32;
    typedef logic [FALCO_XLEN-1:0] xlen_data_t;
endpackage

// File: rtl/L1_cache_pkg.sv
// Shared L1 cache types: arbitration FSM encoding for the single DCache port.
package L1_cache_pkg;
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_LD_WAIT = 2'd1,
        ARB_ST_WAIT = 2'd2
    } dcache_arb_state_t;
endpackage

// File: rtl/dcache_port_arbiter.sv
// Arbitrates LSU loads and store-buffer drains onto one L1 DCache port,
// one outstanding transaction at a time, with bounded store starvation.
module dcache_port_arbiter
    import Falco_pkg::*;
    import L1_cache_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = $bits(xlen_data_t)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_req_valid,
    input  logic [XLEN-1:0]   ld_req_addr,
    output logic              ld_req_ready,
    input  logic              ld_kill,
    output logic              ld_resp_valid,
    output logic [XLEN-1:0]   ld_resp_data,
    input  logic              sb_drain_valid,
    input  logic [XLEN-1:0]   sb_drain_addr,
    input  logic [XLEN-1:0]   sb_drain_data,
    input  logic [XLEN/8-1:0] sb_drain_mask,
    input  logic              sb_full,
    output logic              sb_drain_ready,
    output logic              dc_req_valid,
    output logic              dc_req_we,
    output logic [XLEN-1:0]   dc_req_addr,
    output logic [XLEN-1:0]   dc_req_wdata,
    output logic [XLEN/8-1:0] dc_req_mask,
    input  logic              dc_req_ready,
    input  logic              dc_resp_valid,
    input  logic [XLEN-1:0]   dc_resp_data,
    output logic              busy
);
    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    dcache_arb_state_t state_q, state_d;
    logic [CW-1:0]     starve_cnt_q, starve_cnt_d;
    logic              killed_q, killed_d;

    logic ld_ok;
    logic pick_store;
    logic req_any;
    logic handshake;

    // A squashed load is never a candidate, so a pending store may go instead.
    assign ld_ok      = ld_req_valid && !ld_kill;
    assign pick_store = sb_drain_valid && (sb_full || (starve_cnt_q == LIMIT) || !ld_ok);
    assign req_any    = (state_q == ARB_IDLE) && (pick_store || ld_ok);
    assign handshake  = req_any && dc_req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            starve_cnt_q <= '0;
            killed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            killed_q     <= killed_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        killed_d     = killed_q;
        starve_cnt_d = starve_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (handshake) begin
                    state_d  = pick_store ? ARB_ST_WAIT : ARB_LD_WAIT;
                    killed_d = !pick_store && ld_kill;
                end
            end
            ARB_LD_WAIT: begin
                if (ld_kill) begin
                    killed_d = 1'b1;
                end
                if (dc_resp_valid) begin
                    state_d  = ARB_IDLE;
                    killed_d = 1'b0;
                end
            end
            ARB_ST_WAIT: begin
                if (dc_resp_valid) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        // Counts loads granted past a waiting store; any drain or idle store buffer resets it.
        if (!sb_drain_valid || (handshake && pick_store)) begin
            starve_cnt_d = '0;
        end else if (handshake && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_comb begin
        ld_req_ready   = 1'b0;
        sb_drain_ready = 1'b0;
        ld_resp_valid  = 1'b0;
        ld_resp_data   = '0;
        dc_req_valid   = 1'b0;
        dc_req_we      = 1'b0;
        dc_req_addr    = '0;
        dc_req_wdata   = '0;
        dc_req_mask    = '0;
        busy           = 1'b0;
        if (!rst) begin
            busy           = (state_q != ARB_IDLE);
            dc_req_valid   = req_any;
            ld_req_ready   = handshake && !pick_store;
            sb_drain_ready = handshake && pick_store;
            if (req_any) begin
                if (pick_store) begin
                    dc_req_we    = 1'b1;
                    dc_req_addr  = sb_drain_addr;
                    dc_req_wdata = sb_drain_data;
                    dc_req_mask  = sb_drain_mask;
                end else begin
                    dc_req_addr  = ld_req_addr;
                end
            end
            // A kill arriving together with the data still squashes it.
            if ((state_q == ARB_LD_WAIT) && dc_resp_valid && !killed_q && !ld_kill) begin
                ld_resp_valid = 1'b1;
                ld_resp_data  = dc_resp_data;
            end
        end
    end
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Self-checking bench: directed vector table, multi-cycle sequences and
// randomized traffic against a transaction-level reference model.
module tb_dcache_port_arbiter;
    localparam int LIMIT = 4;
    localparam int NV    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_req_valid, ld_kill, sb_drain_valid, sb_full;
    logic        dc_req_ready, dc_resp_valid;
    logic [31:0] ld_req_addr, sb_drain_addr, sb_drain_data, dc_resp_data;
    logic [3:0]  sb_drain_mask;
    logic        ld_req_ready, ld_resp_valid, sb_drain_ready;
    logic        dc_req_valid, dc_req_we, busy;
    logic [31:0] ld_resp_data, dc_req_addr, dc_req_wdata;
    logic [3:0]  dc_req_mask;

    always #5 clk = ~clk;

    dcache_port_arbiter #(.STARVE_LIMIT(LIMIT), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_req_ready(ld_req_ready),
        .ld_kill(ld_kill), .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
        .sb_drain_valid(sb_drain_valid), .sb_drain_addr(sb_drain_addr),
        .sb_drain_data(sb_drain_data), .sb_drain_mask(sb_drain_mask),
        .sb_full(sb_full), .sb_drain_ready(sb_drain_ready),
        .dc_req_valid(dc_req_valid), .dc_req_we(dc_req_we), .dc_req_addr(dc_req_addr),
        .dc_req_wdata(dc_req_wdata), .dc_req_mask(dc_req_mask), .dc_req_ready(dc_req_ready),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: what is outstanding, how many loads passed a waiting store, squash flag.
    int m_phase    = 0;   // 0 none, 1 load outstanding, 2 store outstanding
    int m_streak   = 0;
    bit m_squashed = 1'b0;

    typedef struct {
        logic [31:0] ld_v, ld_a, kill, sb_v, sb_a, sb_d, sb_m, full, rdy, rv, rd;
        logic [31:0] e_ldr, e_sbr, e_dcv, e_we, e_addr, e_wd, e_m, e_rv, e_rd, e_busy;
    } vec_t;
    vec_t tbl[NV];

    always @(negedge clk) begin
        if (!rst && dc_req_valid && dc_req_ready)
            $display("txn %s addr=%h wdata=%h mask=%h", dc_req_we ? "ST" : "LD",
                     dc_req_addr, dc_req_wdata, dc_req_mask);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic compare_outs(input string tag, input logic e_ldr, input logic e_sbr,
                                input logic e_dcv, input logic e_we, input logic [31:0] e_addr,
                                input logic [31:0] e_wd, input logic [3:0] e_m, input logic e_rv,
                                input logic [31:0] e_rd, input logic e_busy);
        chk({tag, ".ctl{ldr,sbr,dcv,we,rv,busy}"},
            {58'd0, ld_req_ready, sb_drain_ready, dc_req_valid, dc_req_we, ld_resp_valid, busy},
            {58'd0, e_ldr, e_sbr, e_dcv, e_we, e_rv, e_busy});
        if (e_dcv) chk({tag, ".addr"}, {32'd0, dc_req_addr}, {32'd0, e_addr});
        if (e_dcv && e_we) begin
            chk({tag, ".wdata"}, {32'd0, dc_req_wdata}, {32'd0, e_wd});
            chk({tag, ".mask"}, {60'd0, dc_req_mask}, {60'd0, e_m});
        end
        if (e_rv) chk({tag, ".rdata"}, {32'd0, ld_resp_data}, {32'd0, e_rd});
    endtask

    task automatic idle_inputs();
        ld_req_valid = 1'b0; ld_req_addr = '0; ld_kill = 1'b0;
        sb_drain_valid = 1'b0; sb_drain_addr = '0; sb_drain_data = '0; sb_drain_mask = '0;
        sb_full = 1'b0; dc_req_ready = 1'b0; dc_resp_valid = 1'b0; dc_resp_data = '0;
    endtask

    // One cycle checked against the model, then the model absorbs the sampled inputs.
    task automatic tick(input string tag);
        logic e_ldr, e_sbr, e_dcv, e_we, e_rv, e_busy;
        logic [31:0] e_addr, e_wd, e_rd;
        logic [3:0] e_m;
        bit ld_ok, take_st, grant;
        @(negedge clk);
        ld_ok   = ld_req_valid && !ld_kill;
        take_st = sb_drain_valid && (sb_full || m_streak >= LIMIT || !ld_ok);
        e_ldr = 0; e_sbr = 0; e_dcv = 0; e_we = 0; e_rv = 0; e_busy = 0;
        e_addr = '0; e_wd = '0; e_rd = '0; e_m = '0;
        if (!rst) begin
            e_busy = (m_phase != 0);
            if (m_phase == 0 && (take_st || ld_ok)) begin
                e_dcv  = 1;
                e_we   = take_st;
                e_addr = take_st ? sb_drain_addr : ld_req_addr;
                e_wd   = sb_drain_data;
                e_m    = sb_drain_mask;
                e_ldr  = dc_req_ready && !take_st;
                e_sbr  = dc_req_ready && take_st;
            end
            if (m_phase == 1 && dc_resp_valid && !m_squashed && !ld_kill) begin
                e_rv = 1;
                e_rd = dc_resp_data;
            end
        end
        compare_outs(tag, e_ldr, e_sbr, e_dcv, e_we, e_addr, e_wd, e_m, e_rv, e_rd, e_busy);
        @(posedge clk);
        if (rst) begin
            m_phase = 0; m_streak = 0; m_squashed = 0;
        end else begin
            grant = (m_phase == 0) && (take_st || ld_ok) && dc_req_ready;
            if (!sb_drain_valid || (grant && take_st)) m_streak = 0;
            else if (grant && m_streak < LIMIT) m_streak = m_streak + 1;
            case (m_phase)
                0: if (grant) m_phase = take_st ? 2 : 1;
                1: begin
                    if (ld_kill) m_squashed = 1;
                    if (dc_resp_valid) begin m_phase = 0; m_squashed = 0; end
                end
                default: if (dc_resp_valid) m_phase = 0;
            endcase
        end
        #1;
    endtask

    initial begin
        string grants;
        idle_inputs();
        rst = 1'b1;

        // ld_v ld_a kill | sb_v sb_a sb_d sb_m full | rdy rv rd | ldr sbr dcv we addr wd m | rv rd busy
        tbl[0]  = '{1, 'h100, 0, 0, 0, 0, 0, 0, 1, 0, 0,           1, 0, 1, 0, 'h100, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hDEADBEEF,      0, 0, 0, 0, 0, 0, 0, 1, 'hDEADBEEF, 1};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 'h200, 0, 1, 'h300, 'hCAFE0001, 'h5, 1, 1, 0, 0,
                    0, 1, 1, 1, 'h300, 'hCAFE0001, 'h5, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h77,            0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[6]  = '{1, 'h204, 0, 0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 1, 0, 'h204, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 'h204, 0, 0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 1, 0, 'h204, 0, 0, 0, 0, 0};
        tbl[8]  = '{1, 'h204, 0, 0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 1, 0, 'h204, 0, 0, 0, 0, 0};
        tbl[9]  = '{1, 'h204, 0, 0, 0, 0, 0, 0, 1, 0, 0,           1, 0, 1, 0, 'h204, 0, 0, 0, 0, 0};
        tbl[10] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0,               0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h1234,          0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        tbl[12] = '{1, 'h208, 0, 0, 0, 0, 0, 0, 1, 0, 0,           1, 0, 1, 0, 'h208, 0, 0, 0, 0, 0};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h55,            0, 0, 0, 0, 0, 0, 0, 1, 'h55, 1};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h99,            0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[15] = '{1, 'h20C, 1, 0, 0, 0, 0, 0, 1, 0, 0,           0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        // Reset with live requests presented: every output must stay low.
        ld_req_valid = 1'b1; ld_req_addr = 32'h40; dc_req_ready = 1'b1; dc_resp_valid = 1'b1;
        tick("reset0");
        tick("reset1");
        rst = 1'b0;
        idle_inputs();

        for (int i = 0; i < NV; i++) begin
            ld_req_valid   = tbl[i].ld_v[0];  ld_req_addr   = tbl[i].ld_a;  ld_kill = tbl[i].kill[0];
            sb_drain_valid = tbl[i].sb_v[0];  sb_drain_addr = tbl[i].sb_a;
            sb_drain_data  = tbl[i].sb_d;     sb_drain_mask = tbl[i].sb_m[3:0];
            sb_full        = tbl[i].full[0];  dc_req_ready  = tbl[i].rdy[0];
            dc_resp_valid  = tbl[i].rv[0];    dc_resp_data  = tbl[i].rd;
            @(negedge clk);
            compare_outs($sformatf("vec%0d", i), tbl[i].e_ldr[0], tbl[i].e_sbr[0], tbl[i].e_dcv[0],
                         tbl[i].e_we[0], tbl[i].e_addr, tbl[i].e_wd, tbl[i].e_m[3:0],
                         tbl[i].e_rv[0], tbl[i].e_rd, tbl[i].e_busy[0]);
            @(posedge clk); #1;
        end

        // Starvation: loads always valid, one store pending, single-cycle responses.
        idle_inputs();
        rst = 1'b1; tick("starve_rst"); rst = 1'b0;
        ld_req_valid = 1'b1; ld_req_addr = 32'h500;
        sb_drain_valid = 1'b1; sb_drain_addr = 32'h600; sb_drain_data = 32'h0BAD_F00D;
        sb_drain_mask = 4'hC; dc_req_ready = 1'b1; dc_resp_valid = 1'b1; dc_resp_data = 32'h1;
        grants = "";
        for (int c = 0; c < 60 && grants.len() < 10; c++) begin
            @(negedge clk);
            if (ld_req_ready)   grants = {grants, "L"};
            if (sb_drain_ready) grants = {grants, "S"};
            @(posedge clk); #1;
        end
        chk("starve.count", 64'(grants.len()), 64'd10);
        for (int g = 0; g < grants.len(); g++)
            chk($sformatf("starve.grant%0d", g), 64'(grants[g]),
                64'((g % (LIMIT + 1) == LIMIT) ? "S" : "L"));

        // Reset while a store is outstanding, then a stale response after release.
        idle_inputs();
        rst = 1'b1; tick("rsw_rst0"); rst = 1'b0;
        sb_drain_valid = 1'b1; sb_drain_addr = 32'h700; sb_drain_data = 32'h11223344;
        sb_drain_mask = 4'hF; dc_req_ready = 1'b1;
        tick("rsw_grant");
        idle_inputs();
        tick("rsw_wait");
        rst = 1'b1; ld_req_valid = 1'b1; sb_drain_valid = 1'b1; dc_req_ready = 1'b1;
        tick("rsw_rst");
        rst = 1'b0; idle_inputs(); dc_resp_valid = 1'b1; dc_resp_data = 32'hBADBAD00;
        tick("rsw_stale");
        idle_inputs(); ld_req_valid = 1'b1; ld_req_addr = 32'h800; dc_req_ready = 1'b1;
        tick("rsw_ld");
        idle_inputs(); dc_resp_valid = 1'b1; dc_resp_data = 32'h600DF00D;
        tick("rsw_resp");

        // Randomized traffic against the model, with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst            = ($urandom_range(0, 99) == 0);
            ld_req_valid   = ($urandom_range(0, 9) < 7);
            ld_req_addr    = $urandom() & 32'hFFFF_FFFC;
            ld_kill        = ($urandom_range(0, 9) == 0);
            sb_drain_valid = ($urandom_range(0, 1) == 1);
            sb_drain_addr  = $urandom() & 32'hFFFF_FFFC;
            sb_drain_data  = $urandom();
            sb_drain_mask  = 4'($urandom_range(0, 15));
            sb_full        = ($urandom_range(0, 4) == 0);
            dc_req_ready   = ($urandom_range(0, 9) < 6);
            dc_resp_valid  = ($urandom_range(0, 9) < 4);
            dc_resp_data   = $urandom();
            tick($sformatf("rand%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dcache_port_arbiter.md
DCACHE_PORT_ARBITER -- requirements
Module: dcache_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum number of consecutive load grants while a store drain is pending.
REQ-002 Parameter XLEN, default 32: address and data width.
REQ-003 Port clk, input, 1: clock.
REQ-004 Port rst, input, 1: reset; synchronous, active-high.
REQ-005 Port ld_req_valid / ld_req_addr, input, 1 / XLEN: load request from the LSU; address is word-aligned.
REQ-006 Port ld_req_ready, output, 1: load request accepted this cycle.
REQ-007 Port ld_kill, input, 1: the outstanding or presented load is squashed by recovery flush.
REQ-008 Port ld_resp_valid / ld_resp_data, output, 1 / XLEN: load data return, one-cycle pulse.
REQ-009 Port sb_drain_valid / sb_drain_addr / sb_drain_data / sb_drain_mask, input, 1 / XLEN / XLEN / XLEN/8: committed store from the store buffer.
REQ-010 Port sb_full, input, 1: the store buffer is full.
REQ-011 Port sb_drain_ready, output, 1: store drain accepted this cycle.
REQ-012 Port dc_req_valid / dc_req_we / dc_req_addr / dc_req_wdata / dc_req_mask, output, 1 / 1 / XLEN / XLEN / XLEN/8: request to the single L1 DCache port.
REQ-013 Port dc_req_ready, input, 1: the cache accepts the request.
REQ-014 Port dc_resp_valid / dc_resp_data, input, 1 / XLEN: cache completion (load data, or store acknowledge).
REQ-015 Port busy, output, 1: the state is not IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, LD_WAIT and ST_WAIT; only one cache transaction is outstanding at a time.
REQ-017 In IDLE, dc_req_valid SHALL be high when the selected requester is valid; the request fields are driven combinationally from the granted source.
REQ-018 Selection SHALL pick the store when sb_drain_valid and (sb_full or starve_cnt==STARVE_LIMIT or !ld_req_valid); otherwise it picks the load.
REQ-019 A load presented with ld_kill high SHALL NOT be selected.
REQ-020 On the IDLE handshake (dc_req_valid and dc_req_ready), the FSM SHALL assert the selected source's ready for exactly that cycle and go to LD_WAIT or ST_WAIT.
REQ-021 No ready SHALL assert in LD_WAIT or ST_WAIT, and dc_req_valid SHALL be 0 in those states.
REQ-022 On dc_resp_valid in LD_WAIT, the FSM SHALL return to IDLE; ld_resp_valid=1 and ld_resp_data=dc_resp_data in that same cycle, unless the load was killed.
REQ-023 A killed flag SHALL be set by ld_kill in LD_WAIT, or on the accept cycle; it SHALL suppress ld_resp_valid and clear on the return to IDLE.
REQ-024 On dc_resp_valid in ST_WAIT, the FSM SHALL return to IDLE with no load response.
REQ-025 ld_kill in ST_WAIT SHALL have no effect.
REQ-026 starve_cnt SHALL increment (saturating at STARVE_LIMIT) on each load grant made while sb_drain_valid is high.
REQ-027 starve_cnt SHALL clear on any store grant, and on any cycle where sb_drain_valid is low.
REQ-028 A new request SHALL NOT be issued in the same cycle as dc_resp_valid; the earliest next request is the following cycle, giving a 2-cycle minimum turnaround.
REQ-029 dc_resp_valid in IDLE SHALL be ignored.

Reset
REQ-030 On rst, state=IDLE, starve_cnt=0 and killed=0.
REQ-031 On rst, all outputs SHALL be 0, including busy, ld_resp_valid and both readies.
REQ-032 rst during LD_WAIT or ST_WAIT SHALL abandon the transaction; a subsequent stale dc_resp_valid is ignored per REQ-029.

Structure
REQ-033 The state enum dcache_arb_state_t SHALL reside in L1_cache_pkg; xlen_data_t SHALL come from Falco_pkg.
REQ-034 The design is a single module with no sub-modules; the starvation counter is inline.

Verification
REQ-035 Lone load: ld_req_valid=1, addr=0x100, dc_req_ready=1, then dc_resp_valid with data 0xDEADBEEF two cycles later -> ld_req_ready pulses once, dc_req_we=0, ld_resp_valid with 0xDEADBEEF, busy for 2 cycles.
REQ-036 Contention: loads continuously valid, one store valid, STARVE_LIMIT=4, single-cycle responses -> 4 load grants, then the store is granted on the 5th grant and starve_cnt returns to 0.
REQ-037 sb_full=1 with a load and a store both valid -> store granted first, dc_req_we=1 with matching mask and data.
REQ-038 ld_kill pulsed in LD_WAIT -> dc_resp_valid returns the FSM to IDLE, ld_resp_valid stays 0, and the next load is served normally.
REQ-039 rst asserted in ST_WAIT, then dc_resp_valid one cycle after reset release -> all outputs 0, state IDLE, no spurious readies or responses.
REQ-040 Back-to-back loads with dc_req_ready held low for 3 cycles -> request fields stable while waiting, ld_req_ready asserts only on the handshake cycle.
